// File: rtl/task_input_frame_buffer.sv
// Store-and-forward frame buffer: captures one upstream stream frame into a FIFO,
// then replays it downstream under valid/ready with end-of-frame marking.
module task_input_frame_buffer #(
   parameter int  DATA_W     = 8,
   parameter int  DEPTH      = 256,
   parameter bit  AUTO_START = 1'b1,
   localparam int CNT_W      = $clog2(DEPTH) + 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_tdata_valid,
   input  logic [DATA_W-1:0] i_tdata,
   input  logic              i_tdata_last,
   input  logic              i_output_last,
   output logic              o_tready,
   output logic [DATA_W-1:0] o_data,
   output logic              o_valid,
   input  logic              i_ready,
   output logic              o_last,
   output logic [CNT_W-1:0]  o_frame_len,
   output logic              o_busy,
   output logic              o_empty,
   output logic              o_overflow
);

   localparam int PTR_W = $clog2(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_REQ,
      ST_LOAD,
      ST_DROP,
      ST_SEND
   } state_t;

   state_t state_q, state_d;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic [CNT_W-1:0]  frame_len_q, frame_len_d;
   logic              first_q, first_d;
   logic              tready_q, tready_d;
   logic              busy_q, busy_d;
   logic              overflow_q, overflow_d;
   logic              mem_we;

   logic fifo_empty;
   logic send_valid;
   logic up_acc;
   logic dn_acc;

   assign fifo_empty = (count_q == '0);
   assign send_valid = (state_q == ST_SEND) && !fifo_empty;
   assign up_acc     = i_tdata_valid && tready_q;
   assign dn_acc     = send_valid && i_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (!fifo_empty) begin
               state_d = ST_SEND;
            end else if ((first_q && AUTO_START) || i_output_last) begin
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            state_d = ST_LOAD;
         end
         ST_LOAD: begin
            if (up_acc) begin
               if (i_tdata_last) begin
                  state_d = ST_IDLE;
               end else if (count_q == CNT_W'(DEPTH - 1)) begin
                  state_d = ST_DROP;
               end
            end
         end
         ST_DROP: begin
            if (up_acc && i_tdata_last) begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (dn_acc && (count_q == CNT_W'(1))) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // A beat that fills the FIFO without tlast becomes the truncated frame's end.
   always_comb begin
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      count_d     = count_q;
      frame_len_d = frame_len_q;
      first_d     = first_q;
      busy_d      = busy_q;
      overflow_d  = 1'b0;
      mem_we      = 1'b0;
      tready_d    = (state_d == ST_LOAD) || (state_d == ST_DROP);

      if ((state_q == ST_LOAD) && up_acc) begin
         mem_we   = 1'b1;
         wr_ptr_d = wr_ptr_q + PTR_W'(1);
         count_d  = count_q + CNT_W'(1);
         if (i_tdata_last) begin
            first_d     = 1'b0;
            frame_len_d = count_q + CNT_W'(1);
         end else if (count_q == CNT_W'(DEPTH - 1)) begin
            overflow_d  = 1'b1;
            frame_len_d = CNT_W'(DEPTH);
         end
      end

      if ((state_q == ST_DROP) && up_acc && i_tdata_last) begin
         first_d = 1'b0;
      end

      if (state_q == ST_REQ) begin
         busy_d = 1'b1;
      end

      if (dn_acc) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
         count_d  = count_q - CNT_W'(1);
         if (count_q == CNT_W'(1)) begin
            busy_d = 1'b0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         frame_len_q <= '0;
         first_q     <= 1'b1;
         tready_q    <= 1'b0;
         busy_q      <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         frame_len_q <= frame_len_d;
         first_q     <= first_d;
         tready_q    <= tready_d;
         busy_q      <= busy_d;
         overflow_q  <= overflow_d;
      end
   end

   always_ff @(posedge i_clk) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= i_tdata;
      end
   end

   // Read side is a direct FIFO view, so data holds naturally while stalled.
   always_comb begin
      o_valid     = send_valid;
      o_data      = mem_q[rd_ptr_q];
      o_last      = send_valid && (count_q == CNT_W'(1));
      o_tready    = tready_q;
      o_busy      = busy_q;
      o_empty     = fifo_empty;
      o_overflow  = overflow_q;
      o_frame_len = frame_len_q;
   end

endmodule

// File: tb/tb_task_input_frame_buffer.sv
// Self-checking bench for task_input_frame_buffer: directed scenarios plus random
// frames compared against a queue-based model of truncation and replay.
module tb_task_input_frame_buffer;

   localparam int DATA_W = 8;
   localparam int DEPTH  = 8;
   localparam int CNT_W  = 4;

   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_tdata_valid;
   logic [DATA_W-1:0] i_tdata;
   logic              i_tdata_last;
   logic              i_output_last;
   logic              o_tready;
   logic [DATA_W-1:0] o_data;
   logic              o_valid;
   logic              i_ready;
   logic              o_last;
   logic [CNT_W-1:0]  o_frame_len;
   logic              o_busy;
   logic              o_empty;
   logic              o_overflow;

   int total = 0;
   int bad   = 0;
   int ovf_seen = 0;

   logic [DATA_W-1:0] frame_q [$];
   logic [DATA_W-1:0] exp_q [$];
   logic [CNT_W-1:0]  exp_len;
   int                exp_ovf;

   task_input_frame_buffer #(
      .DATA_W    (DATA_W),
      .DEPTH     (DEPTH),
      .AUTO_START(1'b1)
   ) dut (
      .i_clk        (i_clk),
      .i_rst_n      (i_rst_n),
      .i_tdata_valid(i_tdata_valid),
      .i_tdata      (i_tdata),
      .i_tdata_last (i_tdata_last),
      .i_output_last(i_output_last),
      .o_tready     (o_tready),
      .o_data       (o_data),
      .o_valid      (o_valid),
      .i_ready      (i_ready),
      .o_last       (o_last),
      .o_frame_len  (o_frame_len),
      .o_busy       (o_busy),
      .o_empty      (o_empty),
      .o_overflow   (o_overflow)
   );

   always #5 i_clk = ~i_clk;

   always @(negedge i_clk) begin
      if (o_overflow === 1'b1) ovf_seen++;
   end

   initial begin
      #400000;
      $display("[TB] FAIL watchdog expired total=%0d bad=%0d", total, bad);
      $fatal(1, "[TB] watchdog");
   end

   // Model: the first DEPTH beats survive, anything longer raises one overflow pulse.
   task automatic build_model();
      exp_q = {};
      for (int i = 0; i < frame_q.size() && i < DEPTH; i++) exp_q.push_back(frame_q[i]);
      exp_len = CNT_W'(exp_q.size());
      exp_ovf = (frame_q.size() > DEPTH) ? 1 : 0;
   endtask

   task automatic make_random_frame(input int len);
      frame_q = {};
      for (int i = 0; i < len; i++) frame_q.push_back(DATA_W'($urandom));
   endtask

   task automatic send_frame(input bit gaps, input bit with_last);
      int  waitc;
      bit  acc;
      for (int i = 0; i < frame_q.size(); i++) begin
         if (gaps) begin
            int k;
            k = $urandom_range(0, 2);
            repeat (k) begin
               @(negedge i_clk);
               i_tdata_valid = 1'b0;
            end
         end
         waitc = 0;
         acc   = 1'b0;
         while (!acc && waitc < 60) begin
            @(negedge i_clk);
            i_tdata_valid = 1'b1;
            i_tdata       = frame_q[i];
            i_tdata_last  = with_last && (i == frame_q.size() - 1);
            acc           = (o_tready === 1'b1);
            waitc++;
            @(posedge i_clk);
         end
         if (!acc) begin
            total++;
            bad++;
            $display("[TB] FAIL send_timeout beat=%0d got=no_accept want=accept", i);
            break;
         end
      end
      @(negedge i_clk);
      i_tdata_valid = 1'b0;
      i_tdata_last  = 1'b0;
   endtask

   task automatic recv_frame(input int mode);
      int                idx = 0;
      int                cyc = 0;
      bit                prev_stall = 1'b0;
      bit                tready_bad = 1'b0;
      logic [DATA_W-1:0] prev_data = '0;
      logic              exp_last;
      while (idx < exp_q.size() && cyc < 300) begin
         @(negedge i_clk);
         cyc++;
         case (mode)
            0:       i_ready = 1'b1;
            1:       i_ready = ((cyc % 2) == 1);
            default: i_ready = 1'($urandom_range(0, 1));
         endcase
         if (o_tready !== 1'b0) tready_bad = 1'b1;
         if (prev_stall) begin
            total++;
            if (o_valid !== 1'b1 || o_data !== prev_data) begin
               bad++;
               $display("[TB] FAIL stall_hold got=%b/%h want=1/%h", o_valid, o_data, prev_data);
            end
         end
         if (o_valid === 1'b1) begin
            exp_last = (idx == exp_q.size() - 1) ? 1'b1 : 1'b0;
            total++;
            if (o_data !== exp_q[idx]) begin
               bad++;
               $display("[TB] FAIL data[%0d] got=%h want=%h", idx, o_data, exp_q[idx]);
            end
            total++;
            if (o_last !== exp_last) begin
               bad++;
               $display("[TB] FAIL last[%0d] got=%b want=%b", idx, o_last, exp_last);
            end
            total++;
            if (o_frame_len !== exp_len) begin
               bad++;
               $display("[TB] FAIL frame_len got=%0d want=%0d", o_frame_len, exp_len);
            end
            prev_stall = !i_ready;
            prev_data  = o_data;
            if (i_ready) idx++;
         end else begin
            prev_stall = 1'b0;
         end
      end
      total++;
      if (idx != exp_q.size()) begin
         bad++;
         $display("[TB] FAIL recv_count got=%0d want=%0d", idx, exp_q.size());
      end
      @(negedge i_clk);
      i_ready = 1'b0;
      total++;
      if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_empty !== 1'b1) begin
         bad++;
         $display("[TB] FAIL after_send valid/busy/empty got=%b%b%b want=001", o_valid, o_busy, o_empty);
      end
      total++;
      if (tready_bad) begin
         bad++;
         $display("[TB] FAIL tready_in_send got=1 want=0");
      end
      total++;
      if (ovf_seen != exp_ovf) begin
         bad++;
         $display("[TB] FAIL overflow_pulses got=%0d want=%0d", ovf_seen, exp_ovf);
      end
   endtask

   task automatic request_next();
      @(negedge i_clk);
      i_output_last = 1'b1;
      @(negedge i_clk);
      i_output_last = 1'b0;
      total++;
      if (o_tready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL req_tready_early got=%b want=0", o_tready);
      end
      @(negedge i_clk);
      total++;
      if (o_tready !== 1'b1 || o_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL req_tready_busy got=%b%b want=11", o_tready, o_busy);
      end
   endtask

   task automatic run_frame(input bit gaps, input int mode);
      ovf_seen = 0;
      build_model();
      send_frame(gaps, 1'b1);
      recv_frame(mode);
   endtask

   task automatic test_reset();
      i_rst_n = 1'b0;
      i_tdata_valid = 1'b0;
      i_tdata = '0;
      i_tdata_last = 1'b0;
      i_output_last = 1'b0;
      i_ready = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      total++;
      if (o_tready !== 1'b0 || o_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0 ||
          o_overflow !== 1'b0 || o_frame_len !== '0 || o_empty !== 1'b1) begin
         bad++;
         $display("[TB] FAIL reset_state got=%b%b%b%b%b len=%0d empty=%b want=00000 len=0 empty=1",
                  o_tready, o_valid, o_last, o_busy, o_overflow, o_frame_len, o_empty);
      end
      i_rst_n = 1'b1;
      @(negedge i_clk);
      total++;
      if (o_tready !== 1'b0) begin
         bad++;
         $display("[TB] FAIL autostart_early got=%b want=0", o_tready);
      end
      @(negedge i_clk);
      total++;
      if (o_tready !== 1'b1 || o_busy !== 1'b1) begin
         bad++;
         $display("[TB] FAIL autostart_tready_busy got=%b%b want=11", o_tready, o_busy);
      end
   endtask

   task automatic test_basic_frame();
      frame_q = {8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(1'b0, 0);
   endtask

   task automatic test_output_last_gate();
      for (int i = 0; i < 5; i++) begin
         @(negedge i_clk);
         total++;
         if (o_tready !== 1'b0 || o_busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL gate_hold[%0d] tready/busy got=%b%b want=00", i, o_tready, o_busy);
         end
      end
      request_next();
   endtask

   task automatic test_stall();
      frame_q = {8'h11, 8'h22, 8'h33, 8'h44};
      run_frame(1'b0, 1);
   endtask

   task automatic test_single_beat();
      request_next();
      frame_q = {8'hA5};
      run_frame(1'b0, 0);
   endtask

   task automatic test_overflow();
      request_next();
      make_random_frame(12);
      run_frame(1'b0, 0);
      request_next();
      make_random_frame(DEPTH);
      run_frame(1'b1, 2);
      request_next();
      make_random_frame(DEPTH + 1);
      run_frame(1'b1, 2);
   endtask

   task automatic test_reset_mid_load();
      request_next();
      make_random_frame(3);
      send_frame(1'b0, 1'b0);
      @(negedge i_clk);
      i_rst_n = 1'b0;
      @(negedge i_clk);
      total++;
      if (o_tready !== 1'b0 || o_valid !== 1'b0 || o_last !== 1'b0 || o_busy !== 1'b0 ||
          o_overflow !== 1'b0 || o_frame_len !== '0 || o_empty !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midload_reset got=%b%b%b%b%b len=%0d empty=%b want=00000 len=0 empty=1",
                  o_tready, o_valid, o_last, o_busy, o_overflow, o_frame_len, o_empty);
      end
      i_rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge i_clk);
         total++;
         if (o_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL midload_no_emit[%0d] got=%b want=0", i, o_valid);
         end
      end
      total++;
      if (o_tready !== 1'b1) begin
         bad++;
         $display("[TB] FAIL midload_restart got=%b want=1", o_tready);
      end
      make_random_frame(4);
      run_frame(1'b1, 2);
   endtask

   task automatic test_random();
      for (int n = 0; n < 8; n++) begin
         request_next();
         make_random_frame($urandom_range(1, DEPTH + 4));
         run_frame(1'b1, 2);
      end
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_output_last_gate();
      test_stall();
      test_single_beat();
      test_overflow();
      test_reset_mid_load();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
